// File: rtl/writeback_pkg.sv
// rtl/writeback_pkg.sv - shared widths and write-back source encodings
package writeback_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 3;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_MEM  = 2'b01,
    WB_INP  = 2'b10,
    WB_NONE = 2'b11
  } wb_sel_e;

endpackage

// File: rtl/writeback_stage_mem_wb_reg.sv
// rtl/writeback_stage_mem_wb_reg.sv - MEM/WB pipeline register with stall and flush
module mem_wb_reg #(
  parameter int DATA_W     = writeback_pkg::DATA_W,
  parameter int REG_ADDR_W = writeback_pkg::REG_ADDR_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_stall,
  input  logic                  i_flush,
  input  logic                  i_valid,
  input  logic                  i_regwrite,
  input  logic [1:0]            i_wbsel,
  input  logic                  i_outen,
  input  logic [REG_ADDR_W-1:0] i_rdst,
  input  logic [DATA_W-1:0]     i_data,
  input  logic [DATA_W-1:0]     i_result,
  input  logic [DATA_W-1:0]     i_inport,
  output logic                  o_valid,
  output logic                  o_regwrite,
  output logic [1:0]            o_wbsel,
  output logic                  o_outen,
  output logic [REG_ADDR_W-1:0] o_rdst,
  output logic [DATA_W-1:0]     o_data,
  output logic [DATA_W-1:0]     o_result,
  output logic [DATA_W-1:0]     o_inport
);

  logic                  r_valid;
  logic                  r_regwrite;
  logic [1:0]            r_wbsel;
  logic                  r_outen;
  logic [REG_ADDR_W-1:0] r_rdst;
  logic [DATA_W-1:0]     r_data;
  logic [DATA_W-1:0]     r_result;
  logic [DATA_W-1:0]     r_inport;

  // Flush only kills the valid bit; the payload is left as don't-care.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_wbsel    <= 2'b00;
      r_outen    <= 1'b0;
      r_rdst     <= '0;
      r_data     <= '0;
      r_result   <= '0;
      r_inport   <= '0;
    end else if (i_flush) begin
      r_valid    <= 1'b0;
    end else if (!i_stall) begin
      r_valid    <= i_valid;
      r_regwrite <= i_regwrite;
      r_wbsel    <= i_wbsel;
      r_outen    <= i_outen;
      r_rdst     <= i_rdst;
      r_data     <= i_data;
      r_result   <= i_result;
      r_inport   <= i_inport;
    end
  end

  assign o_valid    = r_valid;
  assign o_regwrite = r_regwrite;
  assign o_wbsel    = r_wbsel;
  assign o_outen    = r_outen;
  assign o_rdst     = r_rdst;
  assign o_data     = r_data;
  assign o_result   = r_result;
  assign o_inport   = r_inport;

endmodule

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - write-back mux, output port register and retire counter
module writeback_stage #(
  parameter int DATA_W     = writeback_pkg::DATA_W,
  parameter int REG_ADDR_W = writeback_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic                  RegWrite,
  input  logic [1:0]            WbSel,
  input  logic                  OutEn,
  input  logic [REG_ADDR_W-1:0] Rdst,
  input  logic [DATA_W-1:0]     Data,
  input  logic [DATA_W-1:0]     Data_result,
  input  logic [DATA_W-1:0]     InPortValue,
  output logic                  wb_en,
  output logic [REG_ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0]     wb_data,
  output logic [DATA_W-1:0]     out_port,
  output logic [15:0]           retired_count
);

  import writeback_pkg::*;

  logic                  w_valid_q;
  logic                  w_regwrite_q;
  logic [1:0]            w_wbsel_q;
  logic                  w_outen_q;
  logic [REG_ADDR_W-1:0] w_rdst_q;
  logic [DATA_W-1:0]     w_data_q;
  logic [DATA_W-1:0]     w_result_q;
  logic [DATA_W-1:0]     w_inport_q;
  logic                  w_hold;

  logic [DATA_W-1:0]     r_out_port;
  logic [15:0]           r_retired;

  mem_wb_reg #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_mem_wb_reg (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_stall    (stall),
    .i_flush    (flush),
    .i_valid    (in_valid),
    .i_regwrite (RegWrite),
    .i_wbsel    (WbSel),
    .i_outen    (OutEn),
    .i_rdst     (Rdst),
    .i_data     (Data),
    .i_result   (Data_result),
    .i_inport   (InPortValue),
    .o_valid    (w_valid_q),
    .o_regwrite (w_regwrite_q),
    .o_wbsel    (w_wbsel_q),
    .o_outen    (w_outen_q),
    .o_rdst     (w_rdst_q),
    .o_data     (w_data_q),
    .o_result   (w_result_q),
    .o_inport   (w_inport_q)
  );

  // Flush wins over stall, so the held instruction retires on a flush edge.
  assign w_hold = stall & ~flush;

  assign wb_en   = w_valid_q & w_regwrite_q;
  assign wb_addr = w_rdst_q;

  always_comb begin
    wb_data = '0;
    case (w_wbsel_q)
      WB_ALU:  wb_data = w_result_q;
      WB_MEM:  wb_data = w_data_q;
      WB_INP:  wb_data = w_inport_q;
      default: wb_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_port <= '0;
      r_retired  <= '0;
    end else begin
      if (w_valid_q && w_outen_q) begin
        r_out_port <= w_result_q;
      end
      if (w_valid_q && !w_hold) begin
        r_retired <= r_retired + 16'd1;
      end
    end
  end

  assign out_port      = r_out_port;
  assign retired_count = r_retired;

endmodule

// File: tb/tb_writeback_stage.sv
// tb/tb_writeback_stage.sv - directed self-checking bench for writeback_stage
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic        in_valid;
  logic        RegWrite;
  logic [1:0]  WbSel;
  logic        OutEn;
  logic [2:0]  Rdst;
  logic [15:0] Data;
  logic [15:0] Data_result;
  logic [15:0] InPortValue;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic [15:0] out_port;
  logic [15:0] retired_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  writeback_stage dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .flush         (flush),
    .in_valid      (in_valid),
    .RegWrite      (RegWrite),
    .WbSel         (WbSel),
    .OutEn         (OutEn),
    .Rdst          (Rdst),
    .Data          (Data),
    .Data_result   (Data_result),
    .InPortValue   (InPortValue),
    .wb_en         (wb_en),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .out_port      (out_port),
    .retired_count (retired_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic [1:0] sel, input logic oe,
                       input logic [2:0] rd, input logic [15:0] d, input logic [15:0] res,
                       input logic [15:0] inp);
    in_valid = v; RegWrite = rw; WbSel = sel; OutEn = oe;
    Rdst = rd; Data = d; Data_result = res; InPortValue = inp;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0;
    drive(1'b1, 1'b1, 2'b01, 1'b1, 3'd7, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    step(); step();
    drive(1'b0, 1'b0, 2'b00, 1'b0, 3'd0, 16'h0, 16'h0, 16'h0);
    rst = 1'b0;
    n_cmp++; if (wb_en !== 1'b0) begin n_err++; $display("FAIL reset_wb_en: got %0b want 0", wb_en); end
    n_cmp++; if (wb_addr !== 3'd0) begin n_err++; $display("FAIL reset_wb_addr: got %0d want 0", wb_addr); end
    n_cmp++; if (wb_data !== 16'h0) begin n_err++; $display("FAIL reset_wb_data: got %h want 0000", wb_data); end
    n_cmp++; if (out_port !== 16'h0) begin n_err++; $display("FAIL reset_out_port: got %h want 0000", out_port); end
    n_cmp++; if (retired_count !== 16'h0) begin n_err++; $display("FAIL reset_count: got %h want 0000", retired_count); end
  endtask

  task automatic test_load();
    drive(1'b1, 1'b1, 2'b01, 1'b0, 3'd3, 16'hBEEF, 16'h1111, 16'h2222);
    step();
    n_cmp++; if (wb_en !== 1'b1) begin n_err++; $display("FAIL load_wb_en: got %0b want 1", wb_en); end
    n_cmp++; if (wb_addr !== 3'd3) begin n_err++; $display("FAIL load_wb_addr: got %0d want 3", wb_addr); end
    n_cmp++; if (wb_data !== 16'hBEEF) begin n_err++; $display("FAIL load_wb_data: got %h want beef", wb_data); end
    n_cmp++; if (retired_count !== 16'd0) begin n_err++; $display("FAIL load_count0: got %h want 0000", retired_count); end
    drive(1'b0, 1'b1, 2'b01, 1'b0, 3'd3, 16'hBEEF, 16'h1111, 16'h2222);
    step();
    n_cmp++; if (wb_en !== 1'b0) begin n_err++; $display("FAIL load_bubble_wb_en: got %0b want 0", wb_en); end
    n_cmp++; if (retired_count !== 16'd1) begin n_err++; $display("FAIL load_count1: got %h want 0001", retired_count); end
  endtask

  task automatic test_wb_mux();
    drive(1'b1, 1'b1, 2'b10, 1'b0, 3'd7, 16'h5678, 16'h1234, 16'hCAFE);
    step();
    n_cmp++; if (wb_data !== 16'hCAFE) begin n_err++; $display("FAIL mux_inp: got %h want cafe", wb_data); end
    n_cmp++; if (wb_addr !== 3'd7) begin n_err++; $display("FAIL mux_inp_addr: got %0d want 7", wb_addr); end
    drive(1'b1, 1'b1, 2'b11, 1'b0, 3'd6, 16'h5678, 16'h1234, 16'hCAFE);
    step();
    n_cmp++; if (wb_data !== 16'h0000) begin n_err++; $display("FAIL mux_none: got %h want 0000", wb_data); end
    n_cmp++; if (wb_en !== 1'b1) begin n_err++; $display("FAIL mux_none_en: got %0b want 1", wb_en); end
    drive(1'b1, 1'b1, 2'b00, 1'b0, 3'd2, 16'h5678, 16'h1234, 16'hCAFE);
    step();
    n_cmp++; if (wb_data !== 16'h1234) begin n_err++; $display("FAIL mux_alu: got %h want 1234", wb_data); end
    drive(1'b0, 1'b0, 2'b00, 1'b0, 3'd0, 16'h0, 16'h0, 16'h0);
    step();
    n_cmp++; if (retired_count !== 16'd4) begin n_err++; $display("FAIL mux_count: got %h want 0004", retired_count); end
  endtask

  task automatic test_stall_flush();
    drive(1'b1, 1'b1, 2'b00, 1'b0, 3'd5, 16'h0, 16'h0012, 16'h0);
    step();
    drive(1'b1, 1'b1, 2'b01, 1'b1, 3'd1, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (wb_en !== 1'b1) begin n_err++; $display("FAIL stall_wb_en[%0d]: got %0b want 1", i, wb_en); end
      n_cmp++; if (wb_data !== 16'h0012) begin n_err++; $display("FAIL stall_wb_data[%0d]: got %h want 0012", i, wb_data); end
      n_cmp++; if (wb_addr !== 3'd5) begin n_err++; $display("FAIL stall_wb_addr[%0d]: got %0d want 5", i, wb_addr); end
      n_cmp++; if (retired_count !== 16'd4) begin n_err++; $display("FAIL stall_count[%0d]: got %h want 0004", i, retired_count); end
      n_cmp++; if (out_port !== 16'h0) begin n_err++; $display("FAIL stall_out_port[%0d]: got %h want 0000", i, out_port); end
    end
    flush = 1'b1;
    step();
    n_cmp++; if (wb_en !== 1'b0) begin n_err++; $display("FAIL flush_wb_en: got %0b want 0", wb_en); end
    n_cmp++; if (retired_count !== 16'd5) begin n_err++; $display("FAIL flush_count: got %h want 0005", retired_count); end
    stall = 1'b0;
    drive(1'b1, 1'b1, 2'b00, 1'b0, 3'd4, 16'h0, 16'h3333, 16'h0);
    step();
    n_cmp++; if (wb_en !== 1'b0) begin n_err++; $display("FAIL flush_only_wb_en: got %0b want 0", wb_en); end
    flush = 1'b0;
    drive(1'b0, 1'b0, 2'b00, 1'b0, 3'd0, 16'h0, 16'h0, 16'h0);
    step();
    n_cmp++; if (retired_count !== 16'd5) begin n_err++; $display("FAIL flush_only_count: got %h want 0005", retired_count); end
  endtask

  task automatic test_out();
    drive(1'b1, 1'b0, 2'b00, 1'b1, 3'd4, 16'h0, 16'h00A5, 16'h0);
    step();
    n_cmp++; if (wb_en !== 1'b0) begin n_err++; $display("FAIL out_wb_en: got %0b want 0", wb_en); end
    n_cmp++; if (out_port !== 16'h0) begin n_err++; $display("FAIL out_early: got %h want 0000", out_port); end
    drive(1'b0, 1'b0, 2'b00, 1'b1, 3'd4, 16'h0, 16'h5A5A, 16'h0);
    step();
    n_cmp++; if (out_port !== 16'h00A5) begin n_err++; $display("FAIL out_load: got %h want 00a5", out_port); end
    step(); step();
    n_cmp++; if (out_port !== 16'h00A5) begin n_err++; $display("FAIL out_hold: got %h want 00a5", out_port); end
    n_cmp++; if (retired_count !== 16'd6) begin n_err++; $display("FAIL out_count: got %h want 0006", retired_count); end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b1, 2'b00, 1'b1, 3'd6, 16'h0, 16'h7777, 16'h0);
    step();
    n_cmp++; if (wb_en !== 1'b1) begin n_err++; $display("FAIL mid_pre_wb_en: got %0b want 1", wb_en); end
    drive(1'b0, 1'b0, 2'b00, 1'b0, 3'd0, 16'h0, 16'h0, 16'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if (wb_en !== 1'b0) begin n_err++; $display("FAIL mid_wb_en: got %0b want 0", wb_en); end
    n_cmp++; if (wb_addr !== 3'd0) begin n_err++; $display("FAIL mid_wb_addr: got %0d want 0", wb_addr); end
    n_cmp++; if (wb_data !== 16'h0) begin n_err++; $display("FAIL mid_wb_data: got %h want 0000", wb_data); end
    n_cmp++; if (out_port !== 16'h0) begin n_err++; $display("FAIL mid_out_port: got %h want 0000", out_port); end
    n_cmp++; if (retired_count !== 16'h0) begin n_err++; $display("FAIL mid_count: got %h want 0000", retired_count); end
    step();
    n_cmp++; if (wb_en !== 1'b0) begin n_err++; $display("FAIL mid_stale_wb_en: got %0b want 0", wb_en); end
    n_cmp++; if (retired_count !== 16'h0) begin n_err++; $display("FAIL mid_stale_count: got %h want 0000", retired_count); end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b0, 2'b00, 1'b0, 3'd1, 16'h0, 16'h0, 16'h0);
    step();
    for (int i = 0; i < 65534; i++) step();
    n_cmp++; if (retired_count !== 16'hFFFE) begin n_err++; $display("FAIL wrap_fffe: got %h want fffe", retired_count); end
    step();
    n_cmp++; if (retired_count !== 16'hFFFF) begin n_err++; $display("FAIL wrap_ffff: got %h want ffff", retired_count); end
    step();
    n_cmp++; if (retired_count !== 16'h0000) begin n_err++; $display("FAIL wrap_0000: got %h want 0000", retired_count); end
    step();
    n_cmp++; if (retired_count !== 16'h0001) begin n_err++; $display("FAIL wrap_0001: got %h want 0001", retired_count); end
    drive(1'b0, 1'b0, 2'b00, 1'b0, 3'd0, 16'h0, 16'h0, 16'h0);
  endtask

  initial begin
    test_reset();
    test_load();
    test_wb_mux();
    test_stall_flush();
    test_out();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Parameters SHALL be: DATA_W, default 16, datapath width; REG_ADDR_W, default 3, register-file address width (8 registers).
REQ-002 Single clock, reset synchronous and active-high; ports as follows:
  clk  in  1  rising-edge clock
  rst  in  1  synchronous active-high reset
  stall  in  1  hold the MEM/WB register contents
  flush  in  1  replace the captured instruction with a bubble
  in_valid  in  1  MEM stage holds a real instruction
  RegWrite  in  1  instruction writes the register file
  WbSel  in  2  write-back source select
  OutEn  in  1  instruction is OUT (drives the output port)
  Rdst  in  REG_ADDR_W  destination register
  Data  in  DATA_W  memory read data from the Memory stage
  Data_result  in  DATA_W  ALU result passed through the Memory stage
  InPortValue  in  DATA_W  sampled input-port value
  wb_en  out  1  register-file write enable
  wb_addr  out  REG_ADDR_W  register-file write address
  wb_data  out  DATA_W  register-file write data, also the forwarding source
  out_port  out  DATA_W  registered processor output port
  retired_count  out  16  count of retired valid instructions

Function
REQ-003 The MEM/WB register SHALL capture in_valid, RegWrite, WbSel, OutEn, Rdst, Data, Data_result and InPortValue on the rising clk edge when not stalled and not flushed.
REQ-004 Priority at each edge SHALL be rst > flush > stall > capture.
REQ-005 flush SHALL clear the registered valid bit; the data fields are don't-care.
REQ-006 stall SHALL hold every registered field unchanged.
REQ-007 Latency SHALL be one cycle: an instruction captured at edge N drives wb_* during cycle N..N+1.
REQ-008 wb_en SHALL equal valid_q AND RegWrite_q (combinational from the register).
REQ-009 wb_addr SHALL equal Rdst_q.
REQ-010 wb_data SHALL be driven combinationally from WbSel_q: 00 selects Data_result_q; 01 selects Data_q; 10 selects InPortValue_q; 11 selects zero.
REQ-011 out_port SHALL load Data_result_q at any edge where valid_q AND OutEn_q is true and rst is low.
REQ-012 out_port SHALL hold its value otherwise, including while stalled (reloading the same value is permitted).
REQ-013 retired_count SHALL increment by 1 at each edge where valid_q is true and stall is low.
REQ-014 retired_count SHALL wrap from 16'hFFFF to 16'h0000.
REQ-015 A bubble (valid_q = 0) SHALL never assert wb_en, update out_port, or increment retired_count.
REQ-016 When flush and stall are asserted together, the stage SHALL flush.

Reset
REQ-017 While rst is high at an edge, valid_q SHALL be 0 and all registered fields, out_port and retired_count SHALL be 0.
REQ-018 Therefore wb_en = 0, wb_addr = 0 and wb_data = 0 in the cycle after reset.
REQ-019 An instruction in flight when reset is asserted SHALL be discarded and SHALL NOT produce wb_en after reset deasserts.

Structure
REQ-020 A shared package SHALL hold DATA_W, REG_ADDR_W and the WbSel encodings WB_ALU = 2'b00, WB_MEM = 2'b01, WB_INP = 2'b10 and WB_NONE = 2'b11.
REQ-021 The pipeline register SHALL be a sub-module mem_wb_reg with stall and flush inputs; the write-back mux, output-port register and retire counter live in writeback_stage.

Verification
REQ-022 Load: in_valid=1, RegWrite=1, WbSel=01, Rdst=3, Data=16'hBEEF -> the next cycle shows wb_en=1, wb_addr=3 and wb_data=16'hBEEF.
REQ-023 Stall then flush: capture an ALU result 16'h0012 to R5, hold stall for 3 cycles, then assert flush together with stall -> wb_en stays high with 16'h0012 for 3 cycles, then drops to 0; retired_count is unchanged while stalled and increments by 1 on the flush edge.
REQ-024 OUT: in_valid=1, OutEn=1, RegWrite=0, Data_result=16'h00A5 -> wb_en=0, and out_port becomes 16'h00A5 one edge after capture and holds through later bubbles.
REQ-025 Counter wrap: preload retired_count to 16'hFFFE, retire 3 valid instructions back-to-back -> the count reads FFFF, then 0000, then 0001.
REQ-026 Reset mid-operation: a valid RegWrite instruction is in the register and rst=1 for 1 cycle -> wb_en=0, out_port=0 and retired_count=0 afterward, with no stale write.
